// File: rtl/image_feeder.sv
// Streams a captured 32x32 bitmap as 16x16 2x2-pooled pixels (0..4) over a
// valid/ready handshake, one registered pixel per accepted transfer.
module image_feeder #(
  parameter int N_PIX = 256
) (
  input  logic          clkVga,
  input  logic          iRstN,
  input  logic [1023:0] iImage,
  input  logic          iStart,
  input  logic          iAbort,
  input  logic          iReady,
  output logic          oValid,
  output logic [2:0]    oPixel,
  output logic [7:0]    oIndex,
  output logic          oLast,
  output logic          oBusy,
  output logic          oDone
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(N_PIX - 1);

  state_t          state_r;
  logic [1023:0]   snap_r;
  logic [7:0]      cnt_r;
  logic            valid_r;
  logic [2:0]      pixel_r;
  logic            last_r;
  logic            busy_r;
  logic            done_r;

  logic [7:0]      nxt_cnt_s;
  logic [2:0]      nxt_pix_s;
  logic [2:0]      first_pix_s;
  logic            xfer_s;

  // Bitmap bit address is {x, y}; output pixel (px, py) covers x in 2px..2px+1, y in 2py..2py+1.
  function automatic logic [2:0] pool(input logic [1023:0] img, input logic [7:0] idx);
    logic [4:0] x0;
    logic [4:0] x1;
    logic [4:0] y0;
    logic [4:0] y1;
    x0 = {idx[3:0], 1'b0};
    x1 = {idx[3:0], 1'b1};
    y0 = {idx[7:4], 1'b0};
    y1 = {idx[7:4], 1'b1};
    pool = 3'(img[{x0, y0}]) + 3'(img[{x0, y1}]) + 3'(img[{x1, y0}]) + 3'(img[{x1, y1}]);
  endfunction

  // Next-pixel precompute: the first pixel comes straight from iImage because
  // the snapshot is only being written on the capturing edge.
  always_comb begin
    nxt_cnt_s   = cnt_r + 8'd1;
    nxt_pix_s   = pool(snap_r, nxt_cnt_s);
    first_pix_s = pool(iImage, 8'd0);
    xfer_s      = 1'b0;
    if (valid_r && iReady) begin
      xfer_s = 1'b1;
    end else begin
      xfer_s = 1'b0;
    end
  end

  // Frame FSM with registered handshake outputs; abort always takes priority.
  always_ff @(posedge clkVga or negedge iRstN) begin
    if (!iRstN) begin
      state_r <= IDLE;
      snap_r  <= '0;
      cnt_r   <= 8'd0;
      valid_r <= 1'b0;
      pixel_r <= 3'd0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (iStart && !iAbort) begin
            state_r <= STREAM;
            snap_r  <= iImage;
            cnt_r   <= 8'd0;
            valid_r <= 1'b1;
            pixel_r <= first_pix_s;
            last_r  <= (LAST_IDX == 8'd0);
            busy_r  <= 1'b1;
          end else begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        STREAM: begin
          if (iAbort) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end else if (xfer_s) begin
            if (cnt_r == LAST_IDX) begin
              state_r <= DONE;
              valid_r <= 1'b0;
              last_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              cnt_r   <= nxt_cnt_s;
              pixel_r <= nxt_pix_s;
              last_r  <= (nxt_cnt_s == LAST_IDX);
            end
          end else begin
            valid_r <= valid_r;
          end
        end
        DONE: begin
          state_r <= IDLE;
          cnt_r   <= 8'd0;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 8'd0;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign oValid = valid_r;
  assign oPixel = pixel_r;
  assign oIndex = cnt_r;
  assign oLast  = last_r;
  assign oBusy  = busy_r;
  assign oDone  = done_r;

endmodule

// File: tb/tb_image_feeder.sv
// Directed self-checking bench for image_feeder: pooling, handshake, abort, reset.
module tb_image_feeder;

  logic          clkVga;
  logic          iRstN;
  logic [1023:0] iImage;
  logic          iStart;
  logic          iAbort;
  logic          iReady;
  logic          oValid;
  logic [2:0]    oPixel;
  logic [7:0]    oIndex;
  logic          oLast;
  logic          oBusy;
  logic          oDone;

  int checks = 0;
  int errors = 0;

  image_feeder #(.N_PIX(256)) dut (
    .clkVga(clkVga), .iRstN(iRstN), .iImage(iImage), .iStart(iStart),
    .iAbort(iAbort), .iReady(iReady), .oValid(oValid), .oPixel(oPixel),
    .oIndex(oIndex), .oLast(oLast), .oBusy(oBusy), .oDone(oDone)
  );

  initial clkVga = 1'b0;
  always #5 clkVga = ~clkVga;

  initial begin
    #3000000;
    $display("FAIL timeout watchdog expired");
    $fatal(1, "watchdog");
  end

  // Reference pooling: sum of the four bitmap bits (x*32+y) under output (px,py).
  function automatic logic [2:0] model_pix(input logic [1023:0] img, input int idx);
    int px, py, s;
    px = idx % 16;
    py = idx / 16;
    s = 0;
    for (int dx = 0; dx < 2; dx++)
      for (int dy = 0; dy < 2; dy++)
        s += int'(img[(2*px + dx)*32 + 2*py + dy]);
    return 3'(s);
  endfunction

  function automatic logic [1023:0] rand_img();
    logic [1023:0] img;
    for (int i = 0; i < 32; i++) img[i*32 +: 32] = $urandom;
    return img;
  endfunction

  task automatic step();
    @(posedge clkVga);
    #1;
  endtask

  task automatic test_reset();
    iRstN = 1'b0; iImage = '0; iStart = 1'b0; iAbort = 1'b0; iReady = 1'b0;
    #12;
    checks++;
    if ({oValid, oPixel, oIndex, oLast, oBusy, oDone} !== 15'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b p=%0d i=%0d l=%b b=%b d=%b want all 0",
               oValid, oPixel, oIndex, oLast, oBusy, oDone);
    end
    iRstN = 1'b1;
    step();
  endtask

  task automatic test_all_ones();
    iImage = '1; iReady = 1'b1; iStart = 1'b1;
    step();
    iStart = 1'b0;
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (oValid !== 1'b1 || oIndex !== 8'(k) || oPixel !== 3'd4 || oLast !== (k == 255)) begin
        errors++;
        $display("FAIL ones_pixel k=%0d got v=%b i=%0d p=%0d l=%b want v=1 i=%0d p=4 l=%b",
                 k, oValid, oIndex, oPixel, oLast, k, (k == 255));
      end
      step();
    end
    checks++;
    if (oDone !== 1'b1 || oValid !== 1'b0 || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL ones_done got d=%b v=%b b=%b want d=1 v=0 b=1", oDone, oValid, oBusy);
    end
    step();
    checks++;
    if (oDone !== 1'b0 || oBusy !== 1'b0 || oValid !== 1'b0) begin
      errors++;
      $display("FAIL ones_idle got d=%b b=%b v=%b want 0 0 0", oDone, oBusy, oValid);
    end
  endtask

  task automatic test_corners();
    iImage = '0; iImage[0] = 1'b1; iImage[1023] = 1'b1;
    iReady = 1'b1; iStart = 1'b1;
    step();
    iStart = 1'b0;
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (oValid !== 1'b1 || oIndex !== 8'(k) || oPixel !== ((k == 0 || k == 255) ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL corner_pixel k=%0d got v=%b i=%0d p=%0d want p=%0d",
                 k, oValid, oIndex, oPixel, (k == 0 || k == 255) ? 1 : 0);
      end
      step();
    end
    checks++;
    if (oDone !== 1'b1) begin
      errors++;
      $display("FAIL corner_done got %b want 1", oDone);
    end
    step();
  endtask

  task automatic test_stall();
    logic [1023:0] img;
    int c, xfers, exp_idx;
    img = rand_img();
    iImage = img; iReady = 1'b0; iStart = 1'b1;
    step();
    iStart = 1'b0;
    c = 0; xfers = 0; exp_idx = 0;
    while (oDone !== 1'b1 && c < 2000) begin
      iReady = (c % 4 == 0) || (c % 4 == 3);
      checks++;
      if (oValid !== 1'b1 || oIndex !== 8'(exp_idx) || oPixel !== model_pix(img, exp_idx) ||
          oLast !== (exp_idx == 255)) begin
        errors++;
        $display("FAIL stall_pixel c=%0d got v=%b i=%0d p=%0d l=%b want v=1 i=%0d p=%0d",
                 c, oValid, oIndex, oPixel, oLast, exp_idx, model_pix(img, exp_idx));
      end
      if (iReady) begin
        xfers++;
        exp_idx++;
      end
      c++;
      step();
    end
    checks++;
    if (xfers !== 256 || oDone !== 1'b1) begin
      errors++;
      $display("FAIL stall_count got xfers=%0d done=%b want 256 1", xfers, oDone);
    end
    iReady = 1'b1;
    step();
  endtask

  task automatic test_snapshot();
    logic [1023:0] img;
    img = rand_img();
    iImage = img; iReady = 1'b1; iStart = 1'b1;
    step();
    iStart = 1'b0;
    for (int k = 0; k < 256; k++) begin
      if (k == 2) iImage = '0;
      checks++;
      if (oValid !== 1'b1 || oIndex !== 8'(k) || oPixel !== model_pix(img, k)) begin
        errors++;
        $display("FAIL snapshot_pixel k=%0d got i=%0d p=%0d want p=%0d", k, oIndex, oPixel, model_pix(img, k));
      end
      step();
    end
    checks++;
    if (oDone !== 1'b1) begin
      errors++;
      $display("FAIL snapshot_done got %b want 1", oDone);
    end
    step();
  endtask

  task automatic test_abort();
    logic [1023:0] img;
    logic saw_done;
    img = rand_img();
    iImage = img; iReady = 1'b1; iStart = 1'b1;
    step();
    iStart = 1'b0;
    for (int k = 0; k < 100; k++) step();
    checks++;
    if (oIndex !== 8'd100 || oValid !== 1'b1) begin
      errors++;
      $display("FAIL abort_reach got i=%0d v=%b want 100 1", oIndex, oValid);
    end
    iAbort = 1'b1;
    step();
    iAbort = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
      errors++;
      $display("FAIL abort_exit got v=%b b=%b d=%b want 0 0 0", oValid, oBusy, oDone);
    end
    saw_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (oDone === 1'b1 || oValid === 1'b1) saw_done = 1'b1;
      step();
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet got activity=%b want 0", saw_done);
    end
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    checks++;
    if (oValid !== 1'b1 || oIndex !== 8'd0 || oPixel !== model_pix(img, 0)) begin
      errors++;
      $display("FAIL abort_restart got v=%b i=%0d p=%0d want 1 0 %0d", oValid, oIndex, oPixel, model_pix(img, 0));
    end
    iAbort = 1'b1;
    step();
    iAbort = 1'b0;
  endtask

  task automatic test_abort_last();
    iImage = '1; iReady = 1'b1; iStart = 1'b1;
    step();
    iStart = 1'b0;
    for (int k = 0; k < 255; k++) step();
    checks++;
    if (oIndex !== 8'd255 || oLast !== 1'b1 || oValid !== 1'b1) begin
      errors++;
      $display("FAIL abortlast_reach got i=%0d l=%b v=%b want 255 1 1", oIndex, oLast, oValid);
    end
    iAbort = 1'b1;
    step();
    iAbort = 1'b0;
    checks++;
    if (oDone !== 1'b0 || oValid !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL abortlast_exit got d=%b v=%b b=%b want 0 0 0", oDone, oValid, oBusy);
    end
    step();
  endtask

  task automatic test_abort_start_idle();
    iImage = '1; iStart = 1'b1; iAbort = 1'b1;
    step();
    iStart = 1'b0; iAbort = 1'b0;
    checks++;
    if (oBusy !== 1'b0 || oValid !== 1'b0) begin
      errors++;
      $display("FAIL abort_wins_idle got b=%b v=%b want 0 0", oBusy, oValid);
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    iImage = '1; iReady = 1'b1; iStart = 1'b1;
    step();
    iStart = 1'b0;
    for (int k = 0; k < 50; k++) step();
    checks++;
    if (oIndex !== 8'd50) begin
      errors++;
      $display("FAIL rstmid_reach got i=%0d want 50", oIndex);
    end
    #2 iRstN = 1'b0;
    #1;
    checks++;
    if ({oValid, oPixel, oIndex, oLast, oBusy, oDone} !== 15'd0) begin
      errors++;
      $display("FAIL rstmid_async got v=%b p=%0d i=%0d l=%b b=%b d=%b want all 0",
               oValid, oPixel, oIndex, oLast, oBusy, oDone);
    end
    #2 iRstN = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (oDone === 1'b1 || oValid === 1'b1 || oBusy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet got activity=%b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    iImage = '1; iReady = 1'b1; iStart = 1'b1;
    step();
    for (int k = 0; k < 256; k++) begin
      if (k == 10) iImage = '0;
      checks++;
      if (oValid !== 1'b1 || oIndex !== 8'(k) || oPixel !== 3'd4) begin
        errors++;
        $display("FAIL b2b_pixel k=%0d got v=%b i=%0d p=%0d want 1 %0d 4", k, oValid, oIndex, oPixel, k);
      end
      step();
    end
    checks++;
    if (oDone !== 1'b1 || oValid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done got d=%b v=%b want 1 0", oDone, oValid);
    end
    step();
    checks++;
    if (oValid !== 1'b0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got v=%b b=%b d=%b want 0 0 0", oValid, oBusy, oDone);
    end
    step();
    checks++;
    if (oValid !== 1'b1 || oIndex !== 8'd0 || oPixel !== 3'd0 || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart got v=%b i=%0d p=%0d b=%b want 1 0 0 1", oValid, oIndex, oPixel, oBusy);
    end
    iStart = 1'b0; iAbort = 1'b1;
    step();
    iAbort = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_corners();
    test_stall();
    test_snapshot();
    test_abort();
    test_abort_last();
    test_abort_start_idle();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/image_feeder.md
IMAGE_FEEDER -- requirements
Module: image_feeder

Interface
REQ-001 SHALL have parameter N_PIX, default 256, meaning the number of pooled output pixels per frame (16x16).
REQ-002 SHALL have port clkVga  input  1  pixel/system clock; all state on its rising edge.
REQ-003 SHALL have port iRstN  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iImage  input  1024  drawn 32x32 bitmap; bit index = {x[4:0], y[4:0]} = x*32+y; 1 = inked.
REQ-005 SHALL have port iStart  input  1  request to capture and stream one frame; level-sampled each cycle.
REQ-006 SHALL have port iAbort  input  1  synchronous cancel of the current frame.
REQ-007 SHALL have port iReady  input  1  downstream (DNN input) can accept a pixel this cycle.
REQ-008 SHALL have port oValid  output  1  oPixel/oIndex hold a valid pooled pixel.
REQ-009 SHALL have port oPixel  output  3  pooled intensity, 0..4.
REQ-010 SHALL have port oIndex  output  8  output pixel index = py*16+px.
REQ-011 SHALL have port oLast  output  1  high with oValid on index 255.
REQ-012 SHALL have port oBusy  output  1  high in any state except IDLE.
REQ-013 SHALL have port oDone  output  1  one-cycle pulse after the final transfer.

Function
REQ-014 SHALL implement FSM states IDLE, STREAM, DONE.
REQ-015 IDLE: on iStart=1 and iAbort=0, SHALL copy iImage into an internal 1024-bit snapshot and enter STREAM with counter=0 at the same edge.
REQ-016 All pixel data SHALL come from the snapshot; iImage changes after capture SHALL not affect the frame.
REQ-017 oValid SHALL rise the cycle after iStart was sampled, with oIndex=0 (latency 1 cycle).
REQ-018 Pooled value for (px,py), px,py in 0..15, SHALL equal the count of set snapshot bits at x in {2px,2px+1}, y in {2py,2py+1}; 3-bit unsigned, range 0..4.
REQ-019 Output order SHALL be oIndex 0,1,...,255 (px fastest), none skipped or repeated.
REQ-020 A transfer SHALL occur on a cycle with oValid=1 and iReady=1; only then SHALL the counter advance.
REQ-021 While oValid=1 and iReady=0, oPixel, oIndex and oLast SHALL hold stable; oValid SHALL not drop.
REQ-022 With iReady held high, one pixel per cycle SHALL transfer (256 consecutive cycles).
REQ-023 oPixel, oIndex, oLast and oValid SHALL be registered outputs.
REQ-024 Transfer of index 255 SHALL move to DONE; oValid=0 there; oDone=1 for exactly that one cycle; then IDLE.
REQ-025 iStart in STREAM or DONE SHALL be ignored (no recapture, no restart).
REQ-026 iAbort=1 in STREAM or DONE SHALL return to IDLE next edge with oValid=0, and no oDone pulse.
REQ-027 iAbort=1 with iStart=1 in IDLE SHALL keep IDLE (abort wins).
REQ-028 iAbort and a transfer of index 255 on the same edge: abort wins; no oDone.
REQ-029 iStart held high continuously SHALL start a new frame from the IDLE cycle following DONE.
REQ-030 oIndex SHALL not wrap past 255; the counter is 8 bits and frame end is taken at 255.

Reset
REQ-031 iRstN=0 SHALL asynchronously force IDLE, counter=0, snapshot=0, and oValid, oPixel, oIndex, oLast, oBusy, oDone all =0.
REQ-032 Reset asserted mid-frame SHALL discard the frame; no oDone; streaming resumes only on a new iStart after release.

Verification
REQ-033 iImage all 1s, iStart 1 cycle, iReady=1 -> 256 transfers on consecutive cycles, all oPixel=4, oLast on index 255, oDone 1 cycle later.
REQ-034 iImage only bits x=0,y=0 and x=31,y=31 set -> oIndex 0 oPixel=1, oIndex 255 oPixel=1, all others 0.
REQ-035 iReady toggling 1,0,0,1 repeating -> each index transfers exactly once; data stable during stalls; total 256 transfers.
REQ-036 iImage changed to all 0s two cycles after iStart -> streamed values still match the captured image.
REQ-037 iAbort at index 100 -> oValid=0 next cycle, oBusy=0, no oDone; a new iStart streams from index 0.
REQ-038 iRstN pulsed low at index 50 -> all outputs 0 immediately; no oDone after release.
